colorpxl_hist: RTL and testbench

Builds the per-frame colour-pixel histogram consumed by the centroid block. Takes the raster-ordered 1-bit colour-filter stream for a QQVGA frame and counts passing pixels in 8 column bins of the inner frame. At frame end it sequentially forms the aggregate sums: total, left/right, bin01/67 and bin012/567. It then presents them, registered, with a one-cycle new_frame_proc_o pulse; this pulse drives the centroid block's new_frame_proc_i.

---
 rtl/colorpxl_hist_if.sv | 47 ++++
 rtl/colorpxl_hist.sv | 170 +++++++++++++++++
 tb/tb_colorpxl_hist.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/colorpxl_hist_if.sv
// Pixel stream in, histogram aggregates out, for colorpxl_hist.
// frame_err_o exists only when COLORPXL_HIST_ERR_EN is defined.
interface colorpxl_hist_if #(
    parameter int NP = 14,
    parameter int NH = 11
);
    logic          frame_start_i;
    logic          pxl_vld_i;
    logic          pxl_color_i;
    logic [NP-1:0] colorpxls_o;
    logic [NH-1:0] colorpxls_bin0_o;
    logic [NH-1:0] colorpxls_bin7_o;
    logic [NP-2:0] colorpxls_left_o;
    logic [NP-2:0] colorpxls_rght_o;
    logic [NP-2:0] colorpxls_bin01_o;
    logic [NP-2:0] colorpxls_bin67_o;
    logic [NP-2:0] colorpxls_bin012_o;
    logic [NP-2:0] colorpxls_bin567_o;
    logic          new_frame_proc_o;
`ifdef COLORPXL_HIST_ERR_EN
    logic          frame_err_o;
`endif

    modport master (
        output frame_start_i, pxl_vld_i, pxl_color_i,
`ifdef COLORPXL_HIST_ERR_EN
        input  frame_err_o,
`endif
        input  colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
        input  colorpxls_left_o, colorpxls_rght_o,
        input  colorpxls_bin01_o, colorpxls_bin67_o,
        input  colorpxls_bin012_o, colorpxls_bin567_o,
        input  new_frame_proc_o
    );

    modport slave (
        input  frame_start_i, pxl_vld_i, pxl_color_i,
`ifdef COLORPXL_HIST_ERR_EN
        output frame_err_o,
`endif
        output colorpxls_o, colorpxls_bin0_o, colorpxls_bin7_o,
        output colorpxls_left_o, colorpxls_rght_o,
        output colorpxls_bin01_o, colorpxls_bin67_o,
        output colorpxls_bin012_o, colorpxls_bin567_o,
        output new_frame_proc_o
    );
endinterface

// File: rtl/colorpxl_hist.sv
// Per-frame 8-bin column histogram of colour pixels plus aggregate sums.
// Define COLORPXL_HIST_ERR_EN to add frame_err_o (flags aborted frames).
module colorpxl_hist #(
    parameter int c_img_cols        = 160,
    parameter int c_img_rows        = 120,
    parameter int c_inframe_cols    = 128,
    parameter int c_inframe_rows    = 104,
    parameter int c_hist_bins       = 8,
    parameter int c_nb_inframe_pxls = $clog2(c_inframe_cols * c_inframe_rows),
    parameter int c_nb_hist_val     = $clog2(c_inframe_rows * c_inframe_cols / c_hist_bins)
) (
    input  logic           clk,
    input  logic           rst,
    colorpxl_hist_if.slave io_hist
);
    localparam int CW = $clog2(c_img_cols);
    localparam int RW = $clog2(c_img_rows);
    localparam int NP = c_nb_inframe_pxls;
    localparam int NH = c_nb_hist_val;
    localparam int NS = NP - 1;
    localparam int BW = $clog2(c_hist_bins);
    localparam int SH = $clog2(c_inframe_cols / c_hist_bins);

    localparam logic [CW-1:0] L_COL_LO  = CW'((c_img_cols - c_inframe_cols) / 2);
    localparam logic [CW-1:0] L_COL_HI  = CW'((c_img_cols + c_inframe_cols) / 2 - 1);
    localparam logic [CW-1:0] L_COL_MAX = CW'(c_img_cols - 1);
    localparam logic [RW-1:0] L_ROW_LO  = RW'((c_img_rows - c_inframe_rows) / 2);
    localparam logic [RW-1:0] L_ROW_HI  = RW'((c_img_rows + c_inframe_rows) / 2 - 1);
    localparam logic [RW-1:0] L_ROW_MAX = RW'(c_img_rows - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACCUM = 3'd1;
    localparam logic [2:0] S_SUM1  = 3'd2;
    localparam logic [2:0] S_SUM2  = 3'd3;
    localparam logic [2:0] S_SUM3  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [NH-1:0] r_bin [c_hist_bins];
    logic [NS-1:0] r_bin01, r_bin67, r_bin012, r_bin567;
    logic [NS-1:0] r_mid23, r_mid45;

    logic [NP-1:0] r_out_tot;
    logic [NH-1:0] r_out_b0, r_out_b7;
    logic [NS-1:0] r_out_left, r_out_rght;
    logic [NS-1:0] r_out_b01, r_out_b67, r_out_b012, r_out_b567;
    logic          r_pulse;

    logic          w_abort;
    logic          w_inwin;
    logic [BW-1:0] w_idx;
    logic [NS-1:0] w_left, w_rght;
    logic [NP-1:0] w_tot;

    assign w_abort = (r_state == S_ACCUM) && io_hist.frame_start_i;
    assign w_inwin = (r_col >= L_COL_LO) && (r_col <= L_COL_HI) &&
                     (r_row >= L_ROW_LO) && (r_row <= L_ROW_HI);
    assign w_idx   = BW'((r_col - L_COL_LO) >> SH);

    // Final stage adds total combinationally from the same operands as left/rght
    assign w_left  = r_bin01 + r_mid23;
    assign w_rght  = r_bin67 + r_mid45;
    assign w_tot   = NP'(w_left) + NP'(w_rght);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            for (int i = 0; i < c_hist_bins; i++) r_bin[i] <= '0;
            r_bin01    <= '0;
            r_bin67    <= '0;
            r_bin012   <= '0;
            r_bin567   <= '0;
            r_mid23    <= '0;
            r_mid45    <= '0;
            r_out_tot  <= '0;
            r_out_b0   <= '0;
            r_out_b7   <= '0;
            r_out_left <= '0;
            r_out_rght <= '0;
            r_out_b01  <= '0;
            r_out_b67  <= '0;
            r_out_b012 <= '0;
            r_out_b567 <= '0;
            r_pulse    <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (io_hist.frame_start_i) begin
                        r_state <= S_ACCUM;
                        r_col   <= '0;
                        r_row   <= '0;
                        for (int i = 0; i < c_hist_bins; i++) r_bin[i] <= '0;
                    end
                end
                S_ACCUM: begin
                    if (w_abort) begin
                        r_col <= '0;
                        r_row <= '0;
                        for (int i = 0; i < c_hist_bins; i++) r_bin[i] <= '0;
                    end else if (io_hist.pxl_vld_i) begin
                        if (w_inwin && io_hist.pxl_color_i)
                            r_bin[w_idx] <= r_bin[w_idx] + NH'(1);
                        if (r_col == L_COL_MAX) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                            if (r_row == L_ROW_MAX) r_state <= S_SUM1;
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                S_SUM1: begin
                    r_bin01 <= NS'(r_bin[0]) + NS'(r_bin[1]);
                    r_bin67 <= NS'(r_bin[6]) + NS'(r_bin[7]);
                    r_state <= S_SUM2;
                end
                S_SUM2: begin
                    r_bin012 <= r_bin01 + NS'(r_bin[2]);
                    r_bin567 <= r_bin67 + NS'(r_bin[5]);
                    r_mid23  <= NS'(r_bin[2]) + NS'(r_bin[3]);
                    r_mid45  <= NS'(r_bin[4]) + NS'(r_bin[5]);
                    r_state  <= S_SUM3;
                end
                S_SUM3: begin
                    r_out_tot  <= w_tot;
                    r_out_b0   <= r_bin[0];
                    r_out_b7   <= r_bin[7];
                    r_out_left <= w_left;
                    r_out_rght <= w_rght;
                    r_out_b01  <= r_bin01;
                    r_out_b67  <= r_bin67;
                    r_out_b012 <= r_bin012;
                    r_out_b567 <= r_bin567;
                    r_pulse    <= 1'b1;
                    r_state    <= S_DONE;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef COLORPXL_HIST_ERR_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     r_err <= 1'b0;
        else if (w_abort)            r_err <= 1'b1;
        else if (r_state == S_SUM3)  r_err <= 1'b0;
    end

    assign io_hist.frame_err_o = r_err;
`endif

    assign io_hist.colorpxls_o        = r_out_tot;
    assign io_hist.colorpxls_bin0_o   = r_out_b0;
    assign io_hist.colorpxls_bin7_o   = r_out_b7;
    assign io_hist.colorpxls_left_o   = r_out_left;
    assign io_hist.colorpxls_rght_o   = r_out_rght;
    assign io_hist.colorpxls_bin01_o  = r_out_b01;
    assign io_hist.colorpxls_bin67_o  = r_out_b67;
    assign io_hist.colorpxls_bin012_o = r_out_b012;
    assign io_hist.colorpxls_bin567_o = r_out_b567;
    assign io_hist.new_frame_proc_o   = r_pulse;
endmodule

// File: tb/tb_colorpxl_hist.sv
// Directed table-driven bench for colorpxl_hist.
// Covers full/edge/outside frames, vld gaps, abort and mid-frame reset.
module tb_colorpxl_hist;
    typedef struct {
        int pre;
        int mode;
        bit gaps;
        int tot;
        int b0;
        int b7;
        int left;
        int rght;
        int b01;
        int b67;
        int b012;
        int b567;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulse_cnt = 0;
    int   pulse_cyc = 0;
    int   last_cyc = 0;
    int   p0;
    vec_t tbl [3];
    vec_t prev;
    vec_t zv;

    colorpxl_hist_if #(.NP(14), .NH(11)) hif ();

    colorpxl_hist dut (
        .clk     (clk),
        .rst     (rst),
        .io_hist (hif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hif.new_frame_proc_o) begin
            pulse_cnt++;
            pulse_cyc = cyc;
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, vec_t v);
        chk({tag, "_total"},  int'(hif.colorpxls_o),        v.tot);
        chk({tag, "_bin0"},   int'(hif.colorpxls_bin0_o),   v.b0);
        chk({tag, "_bin7"},   int'(hif.colorpxls_bin7_o),   v.b7);
        chk({tag, "_left"},   int'(hif.colorpxls_left_o),   v.left);
        chk({tag, "_rght"},   int'(hif.colorpxls_rght_o),   v.rght);
        chk({tag, "_bin01"},  int'(hif.colorpxls_bin01_o),  v.b01);
        chk({tag, "_bin67"},  int'(hif.colorpxls_bin67_o),  v.b67);
        chk({tag, "_bin012"}, int'(hif.colorpxls_bin012_o), v.b012);
        chk({tag, "_bin567"}, int'(hif.colorpxls_bin567_o), v.b567);
    endtask

    task automatic chk_err(string name, int exp);
`ifdef COLORPXL_HIST_ERR_EN
        chk(name, int'(hif.frame_err_o), exp);
`endif
    endtask

    function automatic bit colf(int mode, int r, int c);
        bit inw;
        inw = (c >= 16) && (c <= 143) && (r >= 8) && (r <= 111);
        case (mode)
            0:       return 1'b1;
            1:       return !inw;
            3:       return c == 143;
            default: return 1'b0;
        endcase
    endfunction

    task automatic fstart();
        @(negedge clk);
        hif.frame_start_i = 1'b1;
        hif.pxl_vld_i     = 1'b0;
        @(negedge clk);
        hif.frame_start_i = 1'b0;
    endtask

    task automatic run_frame(int mode, int stop_row, bit gaps);
        fstart();
        for (int r = 0; r < 120 && r < stop_row; r++) begin
            for (int c = 0; c < 160; c++) begin
                if (gaps && ((r >= 8 && r <= 15) || r == 119)) begin
                    @(negedge clk);
                    hif.pxl_vld_i   = 1'b0;
                    hif.pxl_color_i = 1'b1;
                end
                @(negedge clk);
                hif.pxl_vld_i   = 1'b1;
                hif.pxl_color_i = colf(mode, r, c);
                last_cyc        = cyc;
            end
        end
        @(negedge clk);
        hif.pxl_vld_i   = 1'b0;
        hif.pxl_color_i = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 0, 1'b0, 13312, 1664, 1664, 6656, 6656, 3328, 3328, 4992, 4992};
        tbl[1] = '{1, 1, 1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2] = '{2, 3, 1'b1, 104, 0, 104, 0, 104, 0, 104, 0, 104};
        zv     = '{default: 0};
        prev   = zv;

        hif.frame_start_i = 1'b0;
        hif.pxl_vld_i     = 1'b0;
        hif.pxl_color_i   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_outs("reset", zv);
        chk("reset_pulse", int'(hif.new_frame_proc_o), 0);
        chk_err("reset_err", 0);

        for (int i = 0; i < 3; i++) begin
            if (tbl[i].pre == 1) begin
                p0 = pulse_cnt;
                run_frame(0, 50, 1'b0);
                fstart();
                repeat (10) @(negedge clk);
                chk("abort_pulses", pulse_cnt - p0, 0);
                chk_outs("abort_hold", prev);
                chk_err("abort_err", 1);
            end else if (tbl[i].pre == 2) begin
                p0 = pulse_cnt;
                run_frame(0, 60, 1'b0);
                @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                repeat (8) @(negedge clk);
                chk("midrst_pulses", pulse_cnt - p0, 0);
                chk_outs("midrst", zv);
                chk_err("midrst_err", 0);
            end
            p0 = pulse_cnt;
            run_frame(tbl[i].mode, 1000, tbl[i].gaps);
            repeat (10) @(negedge clk);
            chk($sformatf("f%0d_pulses", i), pulse_cnt - p0, 1);
            chk($sformatf("f%0d_latency", i), pulse_cyc - last_cyc, 4);
            chk_outs($sformatf("f%0d", i), tbl[i]);
            chk_err($sformatf("f%0d_err", i), 0);
            prev = tbl[i];
        end

        // Stray pixels while idle must neither pulse nor disturb held outputs
        p0 = pulse_cnt;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            hif.pxl_vld_i   = 1'b1;
            hif.pxl_color_i = 1'b1;
        end
        @(negedge clk);
        hif.pxl_vld_i   = 1'b0;
        hif.pxl_color_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_pulses", pulse_cnt - p0, 0);
        chk_outs("idle_hold", prev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
